// File: rtl/rf_wb_sched_pkg.sv
// Shared definitions for the register-file writeback scheduler: register index
// type, r0 index, writeback source encodings and data/counter widths.
package rf_wb_sched_pkg;
  localparam int DATA_W = 32;
  localparam int RW     = 5;
  localparam int CNT_W  = 3;

  typedef logic [RW-1:0] reg_idx_t;

  localparam reg_idx_t R0         = 5'd0;
  localparam logic     WB_SRC_ALU = 1'b0;
  localparam logic     WB_SRC_MEM = 1'b1;
endpackage

// File: rtl/rf_wb_sched_if.sv
// Decode/execute/load-unit/regfile bus of rf_wb_sched. The master modport is the
// pipeline side that drives issue and results; the slave modport is the scheduler.
interface rf_wb_sched_if;
  import rf_wb_sched_pkg::*;

  logic                    issue_valid;
  reg_idx_t                issue_rs;
  reg_idx_t                issue_rt;
  logic                    use_rs;
  logic                    use_rt;
  logic                    issue_wr;
  reg_idx_t                issue_rd;
  logic                    issue_src;
  logic                    issue_stall;

  logic                    alu_valid;
  reg_idx_t                alu_rd;
  logic       [DATA_W-1:0] alu_data;
  logic                    mem_valid;
  reg_idx_t                mem_rd;
  logic       [DATA_W-1:0] mem_data;
  logic                    mem_ready;

  logic                    wb_en;
  reg_idx_t                wb_rd;
  logic       [DATA_W-1:0] wb_data;
  logic                    byp1_hit;
  logic                    byp2_hit;
  logic       [DATA_W-1:0] byp_data;

  modport master (
    output issue_valid, issue_rs, issue_rt, use_rs, use_rt, issue_wr, issue_rd, issue_src,
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  issue_stall, mem_ready, wb_en, wb_rd, wb_data, byp1_hit, byp2_hit, byp_data
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, use_rs, use_rt, issue_wr, issue_rd, issue_src,
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output issue_stall, mem_ready, wb_en, wb_rd, wb_data, byp1_hit, byp2_hit, byp_data
  );
endinterface

// File: rtl/rf_scoreboard.sv
// 32-entry pending-result scoreboard: one set port (issue), one clear port (commit),
// two source read ports plus a destination read port for the WAW check. r0 never pends.
module rf_scoreboard
  import rf_wb_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rd_a_idx,
  input  reg_idx_t rd_b_idx,
  input  reg_idx_t rd_c_idx,
  output logic     rd_a,
  output logic     rd_b,
  output logic     rd_c
);
  logic [31:0] pending;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_idx] = 1'b1;
    if (clr_en) clr_mask[clr_idx] = 1'b1;
  end

  // Set and clear of the same index never coincide, so their order is irrelevant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
  end

  assign rd_a = pending[rd_a_idx];
  assign rd_b = pending[rd_b_idx];
  assign rd_c = pending[rd_c_idx];
endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler: hazard stall, load-slot counting and ALU-priority arbitration
// of the single regfile write port. Optional bypass of wb_data under RF_WB_BYPASS_EN.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int MAX_LOADS = 2
) (
  input logic           clk,
  input logic           rst,
  rf_wb_sched_if.slave  bus
);
  logic             pend_rs;
  logic             pend_rt;
  logic             pend_rd;
  logic             byp1;
  logic             byp2;
  logic             raw;
  logic             waw;
  logic             loads_full;
  logic             stall;
  logic             accept;
  logic             grant_alu;
  logic             grant_mem;
  logic             wb_mem_p1;
  logic             load_inc;
  logic [CNT_W-1:0] load_cnt;

  rf_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept && bus.issue_wr && (bus.issue_rd != R0)),
    .set_idx  (bus.issue_rd),
    .clr_en   (bus.wb_en),
    .clr_idx  (bus.wb_rd),
    .rd_a_idx (bus.issue_rs),
    .rd_b_idx (bus.issue_rt),
    .rd_c_idx (bus.issue_rd),
    .rd_a     (pend_rs),
    .rd_b     (pend_rt),
    .rd_c     (pend_rd)
  );

`ifdef RF_WB_BYPASS_EN
  // A source whose producer is on the write port this cycle takes wb_data directly.
  assign byp1          = bus.issue_valid && bus.use_rs && bus.wb_en && (bus.wb_rd == bus.issue_rs);
  assign byp2          = bus.issue_valid && bus.use_rt && bus.wb_en && (bus.wb_rd == bus.issue_rt);
  assign bus.byp_data  = (byp1 || byp2) ? bus.wb_data : '0;
`else
  assign byp1          = 1'b0;
  assign byp2          = 1'b0;
  assign bus.byp_data  = '0;
`endif
  assign bus.byp1_hit  = byp1;
  assign bus.byp2_hit  = byp2;

  assign raw        = (bus.use_rs && pend_rs && !byp1) || (bus.use_rt && pend_rt && !byp2);
  assign waw        = bus.issue_wr && pend_rd;
  assign loads_full = (bus.issue_src == WB_SRC_MEM) && (load_cnt == CNT_W'(MAX_LOADS));
  assign stall      = bus.issue_valid && (raw || waw || loads_full);
  assign accept     = bus.issue_valid && !stall;
  assign load_inc   = accept && (bus.issue_src == WB_SRC_MEM);

  assign bus.issue_stall = stall;
  assign grant_alu       = bus.alu_valid;
  assign grant_mem       = bus.mem_valid && !bus.alu_valid;
  assign bus.mem_ready   = !bus.alu_valid;

  // p1: granted result on the regfile write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.wb_en   <= 1'b0;
      bus.wb_rd   <= R0;
      bus.wb_data <= '0;
      wb_mem_p1   <= 1'b0;
    end else begin
      bus.wb_en <= (grant_alu && (bus.alu_rd != R0)) || (grant_mem && (bus.mem_rd != R0));
      wb_mem_p1 <= grant_mem;
      if (grant_alu) begin
        bus.wb_rd   <= bus.alu_rd;
        bus.wb_data <= bus.alu_data;
      end else if (grant_mem) begin
        bus.wb_rd   <= bus.mem_rd;
        bus.wb_data <= bus.mem_data;
      end
    end
  end

  // A load slot frees when its return reaches the write port, even for r0 targets.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt <= '0;
    end else begin
      case ({load_inc, wb_mem_p1})
        2'b10:   load_cnt <= load_cnt + CNT_W'(1);
        2'b01:   load_cnt <= load_cnt - CNT_W'(1);
        default: load_cnt <= load_cnt;
      endcase
    end
  end
endmodule
